msg_decrypt: RTL
================

MSG_DECRYPT -- requirements
Module: msg_decrypt

Interface
REQ-001 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port Start, input, 1, level hold; while 1 the block idles, and a run begins when it is 0.
REQ-004 SHALL have port mem_addr, output, 8, single-port data-memory address.
REQ-005 SHALL have port mem_rd_data, input, 8, read data, valid the cycle after mem_addr is presented.
REQ-006 SHALL have ports mem_wr_en (output, 1) and mem_wr_data (output, 8); a write occurs at mem_addr on a rising Clk while mem_wr_en=1.
REQ-007 SHALL have port Ack, output, 1, run complete.
REQ-008 SHALL have port Err, output, 1, no tap pattern matched.
REQ-009 SHALL have ports pat_no (output, 4) and lfsr_init (output, 7), the recovered pattern index and starting state.

Function
REQ-010 Cipher bytes c[0..63] SHALL be read from addresses 64..127; plaintext SHALL be written to addresses 0..63.
REQ-011 Tap table SHALL be constant: 0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B for index 0..8.
REQ-012 LFSR step SHALL be s' = {s[5:0], ^(s & tap)}, 7-bit.
REQ-013 FSM states SHALL be IDLE, LOAD, SEARCH, DECODE, FILL, DONE.
REQ-014 IDLE -> LOAD SHALL occur when Start=0.
REQ-015 LOAD: SHALL read c[0..9] into a 10-entry register buffer, one address per cycle.
REQ-016 LOAD: SHALL set s0 = c[0][6:0] ^ 7'h20.
REQ-017 SEARCH: SHALL test patterns in order 0..8, one LFSR step per cycle, with no memory access.
REQ-018 SEARCH: pattern p SHALL match iff c[i][6:0] ^ s_i == 7'h20 for all i = 1..9.
REQ-019 SEARCH: the lowest matching p SHALL be chosen, then the FSM goes to DECODE.
REQ-020 SEARCH: a mismatch SHALL abort the current pattern early and advance to p+1.
REQ-021 SEARCH: if no pattern matches, Err SHALL be set to 1 and the FSM SHALL go to DONE with no memory writes.
REQ-022 DECODE: the LFSR SHALL restart at s0; each byte i = 0..63 SHALL use a read cycle then an evaluate/write cycle.
REQ-023 DECODE: plaintext SHALL be d_i = {1'b0, c[i][6:0] ^ s_i}; parity is good iff ^c[i] == 0.
REQ-024 DECODE: a byte with bad parity SHALL produce output 8'h80 and SHALL count as non-space.
REQ-025 DECODE: while the leading flag is set, good-parity bytes with d_i = 0x20 SHALL be skipped (no write).
REQ-026 DECODE: the first non-skipped byte SHALL clear the leading flag permanently for the run.
REQ-027 DECODE: each non-skipped byte SHALL be written to address wp, then wp SHALL increment (7-bit, 0..64).
REQ-028 DECODE: after i = 63 the FSM SHALL go to FILL, and FILL SHALL write 0x20 to addresses wp..63, one per cycle.
REQ-029 FILL: if wp = 64, FILL SHALL be skipped.
REQ-030 If all 64 bytes are skipped, FILL SHALL write 0x20 to addresses 0..63.
REQ-031 DONE: Ack SHALL be 1 and mem_wr_en SHALL be 0.
REQ-032 DONE -> IDLE SHALL occur when Start=1; Ack and Err SHALL clear on entering IDLE.
REQ-033 pat_no and lfsr_init SHALL be valid from the end of SEARCH until the next Reset or run start; pat_no SHALL be 4'hF when Err=1.
REQ-034 Start changes outside IDLE and DONE SHALL be ignored.
REQ-035 mem_wr_en SHALL be 1 only in DECODE write cycles and in FILL.
REQ-036 Total run from Start=0 to Ack SHALL be at most 300 cycles.

Reset
REQ-037 Reset=1 SHALL, at the next rising Clk, force IDLE, Ack=0, Err=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, pat_no=0, lfsr_init=0, and clear wp, the leading flag and the buffer.
REQ-038 Reset SHALL take priority over Start in every state, including mid-DECODE.
REQ-039 After Reset no further memory write SHALL occur until a new run starts.

Verification
REQ-040 Scenario: "Mr. Watson, come here. I want to see you." with pre_length 10, pattern 6 (0x5C), init 0x01, encrypted into 64..127 -> addresses 0..40 hold the string, 41..63 hold 0x20, pat_no=6, lfsr_init=0x01, Err=0, Ack=1.
REQ-041 Scenario: same message with pattern 0 and init 0x7F -> pat_no=0 and identical plaintext image.
REQ-042 Scenario: case REQ-040 with bit 7 of c[20] flipped -> address 10 holds 0x80 and all other addresses are unchanged.
REQ-043 Scenario: c[1..9] overwritten so that no pattern matches -> Err=1, Ack=1, pat_no=0xF, and addresses 0..63 untouched.
REQ-044 Scenario: Start held at 1 for 50 cycles after Reset -> no memory access and Ack=0; then Start=0 -> Ack within 300 cycles.
REQ-045 Scenario: Reset pulsed for one cycle mid-DECODE -> mem_wr_en=0 and Ack=0 on the next cycle; with Start=0 a clean rerun then produces the correct image.

Source files
------------

// File: rtl/msg_decrypt.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : msg_decrypt
// Purpose  : Recovers the LFSR tap pattern and seed of a 64-byte cipher block,
//            then decrypts it in place with leading-space stripping and padding.
// Revision : 1.0 - initial release
// ============================================================================
module msg_decrypt (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data,
    output logic       Ack,
    output logic       Err,
    output logic [3:0] pat_no,
    output logic [6:0] lfsr_init
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SEARCH = 3'd2,
        DECODE = 3'd3,
        FILL   = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [6:0] C_SPACE7  = 7'h20;
    localparam logic [7:0] C_SPACE8  = 8'h20;
    localparam logic [7:0] C_BADPAR  = 8'h80;
    localparam logic [7:0] C_CIPHER  = 8'd64;

    function automatic logic [6:0] tap_of(input logic [3:0] p);
        case (p)
            4'd0:    tap_of = 7'h60;
            4'd1:    tap_of = 7'h48;
            4'd2:    tap_of = 7'h78;
            4'd3:    tap_of = 7'h72;
            4'd4:    tap_of = 7'h6A;
            4'd5:    tap_of = 7'h69;
            4'd6:    tap_of = 7'h5C;
            4'd7:    tap_of = 7'h7E;
            default: tap_of = 7'h7B;
        endcase
    endfunction

    state_t      r_state, w_next;
    logic [7:0]  r_buf [0:9];
    logic [6:0]  r_cnt;
    logic        r_phase;
    logic [3:0]  r_idx;
    logic [3:0]  r_pat;
    logic [6:0]  r_s;
    logic [6:0]  r_s0;
    logic [6:0]  r_wp;
    logic        r_lead;
    logic        r_err;
    logic [3:0]  r_pat_no;
    logic [6:0]  r_lfsr_init;

    logic [6:0]  w_s_next;
    logic        w_match;
    logic [6:0]  w_d;
    logic        w_par_ok;
    logic [7:0]  w_out;
    logic        w_write;
    logic [3:0]  w_ld_idx;
    logic        w_wp_full;

    assign w_s_next  = {r_s[5:0], ^(r_s & tap_of(r_pat))};
    assign w_match   = ((r_buf[r_idx][6:0] ^ w_s_next) == C_SPACE7);
    assign w_d       = mem_rd_data[6:0] ^ r_s;
    assign w_par_ok  = ~(^mem_rd_data);
    assign w_out     = w_par_ok ? {1'b0, w_d} : C_BADPAR;
    // Leading spaces are dropped only while nothing has been written yet
    assign w_write   = ~(r_lead & w_par_ok & (w_d == C_SPACE7));
    assign w_ld_idx  = r_cnt[3:0] - 4'd1;
    assign w_wp_full = ((r_wp + {6'd0, w_write}) == 7'd64);

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        mem_addr    = 8'd0;
        mem_wr_en   = 1'b0;
        mem_wr_data = 8'd0;
        case (r_state)
            IDLE: begin
                if (!Start) w_next = LOAD;
            end
            LOAD: begin
                if (r_cnt < 7'd10) mem_addr = C_CIPHER + {1'b0, r_cnt};
                if (r_cnt == 7'd10) w_next = SEARCH;
            end
            SEARCH: begin
                if (w_match && (r_idx == 4'd9))        w_next = DECODE;
                else if (!w_match && (r_pat == 4'd8))  w_next = DONE;
            end
            DECODE: begin
                if (!r_phase) begin
                    mem_addr = C_CIPHER + {1'b0, r_cnt};
                end else begin
                    mem_addr    = {1'b0, r_wp};
                    mem_wr_en   = w_write;
                    mem_wr_data = w_out;
                    if (r_cnt == 7'd63) w_next = w_wp_full ? DONE : FILL;
                end
            end
            FILL: begin
                mem_addr    = {1'b0, r_wp};
                mem_wr_en   = 1'b1;
                mem_wr_data = C_SPACE8;
                if (r_wp == 7'd63) w_next = DONE;
            end
            DONE: begin
                if (Start) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign Ack       = (r_state == DONE);
    assign Err       = r_err;
    assign pat_no    = r_pat_no;
    assign lfsr_init = r_lfsr_init;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k < 10; k++) r_buf[k] <= 8'd0;
            r_cnt       <= 7'd0;
            r_phase     <= 1'b0;
            r_idx       <= 4'd0;
            r_pat       <= 4'd0;
            r_s         <= 7'd0;
            r_s0        <= 7'd0;
            r_wp        <= 7'd0;
            r_lead      <= 1'b0;
            r_err       <= 1'b0;
            r_pat_no    <= 4'd0;
            r_lfsr_init <= 7'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!Start) begin
                        r_cnt       <= 7'd0;
                        r_wp        <= 7'd0;
                        r_lead      <= 1'b1;
                        r_err       <= 1'b0;
                        r_pat_no    <= 4'd0;
                        r_lfsr_init <= 7'd0;
                    end
                end
                LOAD: begin
                    // Read data trails the address by one cycle
                    r_cnt <= r_cnt + 7'd1;
                    if (r_cnt != 7'd0) r_buf[w_ld_idx] <= mem_rd_data;
                    if (r_cnt == 7'd1) r_s0 <= mem_rd_data[6:0] ^ C_SPACE7;
                    if (r_cnt == 7'd10) begin
                        r_pat <= 4'd0;
                        r_idx <= 4'd1;
                        r_s   <= r_s0;
                    end
                end
                SEARCH: begin
                    if (w_match) begin
                        if (r_idx == 4'd9) begin
                            r_pat_no    <= r_pat;
                            r_lfsr_init <= r_s0;
                            r_s         <= r_s0;
                            r_cnt       <= 7'd0;
                            r_phase     <= 1'b0;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                            r_s   <= w_s_next;
                        end
                    end else if (r_pat == 4'd8) begin
                        r_err    <= 1'b1;
                        r_pat_no <= 4'hF;
                    end else begin
                        r_pat <= r_pat + 4'd1;
                        r_idx <= 4'd1;
                        r_s   <= r_s0;
                    end
                end
                DECODE: begin
                    r_phase <= ~r_phase;
                    if (r_phase) begin
                        r_s   <= w_s_next;
                        r_cnt <= r_cnt + 7'd1;
                        if (w_write) begin
                            r_wp   <= r_wp + 7'd1;
                            r_lead <= 1'b0;
                        end
                    end
                end
                FILL: begin
                    r_wp <= r_wp + 7'd1;
                end
                DONE: begin
                    if (Start) r_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
